agn_demod_msin: RTL
===================

# agn_demod_msin

Receiver/demodulator for the amplitude-modulated rectified-sine stream produced by the AGN sine generator. It consumes the magnitude, sign and period-strobe signals and reconstructs a signed sine sample. Once per period it recovers the modulation factor M (8 bit) and the period length in samples, and it tracks lock to the nominal period. It sits at the far end of the generator link, feeding indicators and the M-readback path.

## Interface
- `NP_NOM`, 100: nominal samples per period.
- `TOL`, 2: allowed period deviation, in samples, for a good period.
- `LOCK_N`, 2: consecutive good periods required to enter LOCK.
- `TMO`, 255: ce-sample count without a strobe that forces a return to HUNT. Must be ≤ 255.
- `K_MUL`, 131: M-estimate multiplier.
- `K_SH`, 12: M-estimate right shift. The pair implements 128/(2·2000).

- `clk`, in, 1: single clock, rising edge.
- `rst_n`, in, 1: asynchronous, active-low reset.
- `ce`, in, 1: sample enable. Inputs are sampled only when ce=1.
- `S`, in, 1: sign of the current sample. 1 means positive.
- `CO_SIN`, in, 1: period strobe, already qualified by ce at the source.
- `Mmod_SIN`, in, 12: unsigned magnitude sample.
- `sin_out`, out, 13: signed reconstructed sample, two's complement.
- `m_est`, out, 8: recovered M.
- `period`, out, 8: samples in the last complete period.
- `m_vld`, out, 1: one-clk pulse marking that m_est and period have been updated.
- `sign_err`, out, 1: valid with m_vld. Set when the last period had a wrong S toggle count.
- `lock`, out, 1: high in state LOCK.
- `lost`, out, 1: one-clk pulse on timeout.

## Operation
- Reset values:
  - sin_out=0, m_est=0, period=0.
  - m_vld=0, sign_err=0, lock=0, lost=0.
  - State HUNT; all internal counters and registers 0.
- Sign reconstruction, on every ce sample: sin_out <= S ? +Mmod_SIN : −Mmod_SIN. Zero-extend the magnitude to 13 bits before negating.
- Peak register `pk`:
  - On a ce sample without CO_SIN: pk <= max(pk, Mmod_SIN).
  - On a CO_SIN sample: the old pk is captured as the period peak, then pk <= Mmod_SIN.
- Sample counter `cnt`:
  - On a CO_SIN sample: cnt <= 1.
  - Otherwise on ce: cnt <= cnt+1, saturating at 255.
  - At CO_SIN the captured period value is the old cnt.
- Toggle counter `tg` (2 bit, saturating at 3):
  - Counts changes of S between consecutive ce samples.
  - On CO_SIN it is captured and reset to 0.
  - A correct period has exactly 2 toggles.
- M estimate:
  - m_est = (pk·K_MUL + 2^(K_SH−1)) >> K_SH, saturated to 255.
  - 12×8 product; accumulate at 21 bits.
- State machine, evaluated at CO_SIN samples and on timeout:
  - HUNT:
    - First CO_SIN → ACQ. This strobe only starts a measurement: no m_vld, and pk and cnt restart.
  - ACQ:
    - Each CO_SIN emits a result.
    - A good period is |period − NP_NOM| ≤ TOL and tg==2. Good periods increment a good-counter.
    - A bad period clears the good-counter.
    - good-counter == LOCK_N → LOCK.
  - LOCK:
    - Each CO_SIN emits a result.
    - A bad period → ACQ with the good-counter cleared.
  - Any state other than HUNT:
    - cnt reaching TMO without a strobe → HUNT, and lost pulses.
    - m_vld is not asserted.
- Simultaneous events:
  - A CO_SIN on the same sample where cnt would reach TMO counts as a strobe, not as a timeout.
  - Reset mid-period discards the partial measurement and returns to HUNT.

## Timing
- sin_out: latency 1 clk from the ce sample.
- Result outputs (m_est, period, sign_err, m_vld):
  - Registered 1 clk after the clock edge that samples CO_SIN.
  - The pk/period/tg capture happens at the strobe edge; the multiply is in the following stage.
- m_vld is high for exactly 1 clk, independent of ce.
- lock changes on the same edge as m_vld.
- lost is asserted the clk after the timeout sample.
- Outputs hold between updates.

## Structure
- Shared package `agn_pkg`:
  - State enumeration: HUNT, ACQ, LOCK.
  - Constants: AMP=2000, NP_NOM, and the K_MUL/K_SH pair. These are shared with the generator, so both ends agree on scaling.
- One sub-module, `agn_period_meter`: cnt, tg, pk, the capture registers and the timeout flag.
- The top level holds the FSM, the estimate stage and the sign reconstruction.

## Test plan
- Drive the generator model with M=64 and ce every clock:
  - After HUNT plus 2 good periods, lock=1.
  - Every m_vld shows m_est=64, period=100, sign_err=0.
- M sweep over 1, 100 and 131 → m_est equals M exactly each period. Peak Mmod values are 31, 3125 and 4093.
- ce asserted one clock in three, M=10 → period=100, m_est=10, sin_out latency 1 clk, with a negative value when S=0.
- Suppress CO_SIN after lock → after 255 ce samples, lost pulses for 1 clk, lock=0, and the next strobe yields no m_vld.
- Insert a period of 104 samples while locked → that period's m_vld shows period=104, then lock=0 and the FSM is in ACQ. Two normal periods return lock to 1.
- Force S to stay constant for a whole period → sign_err=1 with that m_vld, and lock drops. Assert rst_n low mid-period → all outputs go to 0 immediately, state HUNT.

Source files
------------

// File: rtl/agn_pkg.sv
// Shared definitions for the AGN sine link (generator and demodulator).
// Holds the receiver state enumeration, the link scaling constants and the
// M-estimate helper so both ends of the link agree on scaling.
package agn_pkg;

  typedef enum logic [1:0] {
    HUNT = 2'd0,
    ACQ  = 2'd1,
    LOCK = 2'd2
  } agn_state_e;

  localparam int unsigned AMP    = 2000;
  localparam int unsigned NP_NOM = 100;
  // K_MUL / 2^K_SH approximates 128 / (2 * AMP).
  localparam int unsigned K_MUL  = 131;
  localparam int unsigned K_SH   = 12;
  localparam int unsigned MAG_W  = 12;
  localparam int unsigned CNT_W  = 8;

  // Rounded, saturated M estimate from a period peak. 12x8 product in 21 bits.
  function automatic logic [7:0] m_estimate(input logic [11:0] pk,
                                            input int unsigned kmul,
                                            input int unsigned ksh);
    logic [20:0] acc;
    logic [20:0] q;
    acc = 21'(pk) * 21'(kmul) + (21'd1 << (ksh - 1));
    q   = acc >> ksh;
    return (q > 21'd255) ? 8'hFF : q[7:0];
  endfunction

endpackage

// File: rtl/agn_period_meter.sv
// Per-period measurement for the AGN demodulator.
// Tracks samples since the last strobe (cnt), S toggles (tg) and the running
// magnitude peak (pk). On a strobe the old values are captured and str_o
// pulses for one clk; when cnt reaches TMO without a strobe tmo_o pulses.
// Ports:
//   clk_i, rst_ni      clock, async active-low reset
//   ce_i               sample enable
//   s_i, co_i, mag_i   sign, period strobe, magnitude sample
//   cap_pk_o           peak of the last complete period
//   cap_cnt_o          sample count of the last complete period
//   cap_tg_o           S toggle count of the last complete period
//   str_o              one-clk pulse after a strobe capture
//   tmo_o              one-clk pulse after a timeout sample
module agn_period_meter
  import agn_pkg::*;
#(
  parameter int unsigned TMO = 255
) (
  input  logic             clk_i,
  input  logic             rst_ni,
  input  logic             ce_i,
  input  logic             s_i,
  input  logic             co_i,
  input  logic [MAG_W-1:0] mag_i,
  output logic [MAG_W-1:0] cap_pk_o,
  output logic [CNT_W-1:0] cap_cnt_o,
  output logic [1:0]       cap_tg_o,
  output logic             str_o,
  output logic             tmo_o
);

  logic [7:0]       cnt_q, cnt_d;
  logic [1:0]       tg_q, tg_d;
  logic [MAG_W-1:0] pk_q, pk_d;
  logic             s_q;
  logic             tmo_d;
  logic [MAG_W-1:0] cap_pk_q;
  logic [7:0]       cap_cnt_q;
  logic [1:0]       cap_tg_q;
  logic             str_q, tmo_q;

  always_comb begin
    cnt_d = (cnt_q == 8'hFF) ? cnt_q : cnt_q + 8'd1;
    // The toggle seen on the strobe sample closes the old period.
    tg_d  = (tg_q == 2'd3 || s_i == s_q) ? tg_q : tg_q + 2'd1;
    pk_d  = (mag_i > pk_q) ? mag_i : pk_q;
    // "Reaching" TMO: a saturated cnt does not re-trigger.
    tmo_d = (({1'b0, cnt_q} + 9'd1) == 9'(TMO));
  end

  always_ff @(posedge clk_i or negedge rst_ni) begin
    if (!rst_ni) begin
      cnt_q     <= '0;
      tg_q      <= '0;
      pk_q      <= '0;
      s_q       <= 1'b0;
      cap_pk_q  <= '0;
      cap_cnt_q <= '0;
      cap_tg_q  <= '0;
      str_q     <= 1'b0;
      tmo_q     <= 1'b0;
    end else begin
      str_q <= 1'b0;
      tmo_q <= 1'b0;
      if (ce_i) begin
        s_q <= s_i;
        if (co_i) begin
          cap_pk_q  <= pk_q;
          cap_cnt_q <= cnt_q;
          cap_tg_q  <= tg_d;
          pk_q      <= mag_i;
          cnt_q     <= 8'd1;
          tg_q      <= '0;
          str_q     <= 1'b1;
        end else begin
          pk_q  <= pk_d;
          cnt_q <= cnt_d;
          tg_q  <= tg_d;
          tmo_q <= tmo_d;
        end
      end
    end
  end

  assign cap_pk_o  = cap_pk_q;
  assign cap_cnt_o = cap_cnt_q;
  assign cap_tg_o  = cap_tg_q;
  assign str_o     = str_q;
  assign tmo_o     = tmo_q;

endmodule

// File: rtl/agn_demod_msin.sv
// AGN rectified-sine demodulator.
// Rebuilds the signed sample from magnitude and sign, recovers M and the
// period length once per period, and tracks lock to the nominal period.
// Ports:
//   clk, rst_n          clock, async active-low reset
//   ce                  sample enable
//   S, CO_SIN, Mmod_SIN sign (1 = positive), period strobe, magnitude
//   sin_out             signed reconstructed sample, 1 clk latency
//   m_est, period       recovered M and last period length
//   m_vld               one-clk pulse when m_est/period/sign_err update
//   sign_err            last period did not have exactly 2 S toggles
//   lock                high while in LOCK
//   lost                one-clk pulse on strobe timeout
module agn_demod_msin #(
  parameter int unsigned NP_NOM = agn_pkg::NP_NOM,
  parameter int unsigned TOL    = 2,
  parameter int unsigned LOCK_N = 2,
  parameter int unsigned TMO    = 255,
  parameter int unsigned K_MUL  = agn_pkg::K_MUL,
  parameter int unsigned K_SH   = agn_pkg::K_SH
) (
  input  logic               clk,
  input  logic               rst_n,
  input  logic               ce,
  input  logic               S,
  input  logic               CO_SIN,
  input  logic [11:0]        Mmod_SIN,
  output logic signed [12:0] sin_out,
  output logic [7:0]         m_est,
  output logic [7:0]         period,
  output logic               m_vld,
  output logic               sign_err,
  output logic               lock,
  output logic               lost
);
  import agn_pkg::*;

  localparam logic [7:0] NOM8 = 8'(NP_NOM);

  logic [11:0] cap_pk;
  logic [7:0]  cap_cnt;
  logic [1:0]  cap_tg;
  logic        cap_str, cap_tmo;

  agn_period_meter #(.TMO(TMO)) u_meter (
    .clk_i     (clk),
    .rst_ni    (rst_n),
    .ce_i      (ce),
    .s_i       (S),
    .co_i      (CO_SIN),
    .mag_i     (Mmod_SIN),
    .cap_pk_o  (cap_pk),
    .cap_cnt_o (cap_cnt),
    .cap_tg_o  (cap_tg),
    .str_o     (cap_str),
    .tmo_o     (cap_tmo)
  );

  agn_state_e         state_q;
  logic [7:0]         good_q;
  logic [8:0]         good_d;
  logic [7:0]         est_d;
  logic [7:0]         dev;
  logic               period_ok;
  logic signed [12:0] sin_q;
  logic [7:0]         m_est_q, period_q;
  logic               m_vld_q, sign_err_q, lock_q, lost_q;

  always_comb begin
    est_d     = m_estimate(cap_pk, K_MUL, K_SH);
    dev       = (cap_cnt >= NOM8) ? cap_cnt - NOM8 : NOM8 - cap_cnt;
    period_ok = ({1'b0, dev} <= 9'(TOL)) && (cap_tg == 2'd2);
    good_d    = {1'b0, good_q} + 9'd1;
  end

  // Capture happened on the strobe edge; decisions and the estimate land here.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q    <= HUNT;
      good_q     <= '0;
      sin_q      <= '0;
      m_est_q    <= '0;
      period_q   <= '0;
      m_vld_q    <= 1'b0;
      sign_err_q <= 1'b0;
      lock_q     <= 1'b0;
      lost_q     <= 1'b0;
    end else begin
      m_vld_q <= 1'b0;
      lost_q  <= 1'b0;
      if (ce) begin
        sin_q <= S ? {1'b0, Mmod_SIN} : 13'd0 - {1'b0, Mmod_SIN};
      end
      if (cap_str) begin
        if (state_q == HUNT) begin
          state_q <= ACQ;
          good_q  <= '0;
        end else begin
          m_vld_q    <= 1'b1;
          m_est_q    <= est_d;
          period_q   <= cap_cnt;
          sign_err_q <= (cap_tg != 2'd2);
          if (!period_ok) begin
            state_q <= ACQ;
            good_q  <= '0;
            lock_q  <= 1'b0;
          end else if (state_q == ACQ) begin
            if (good_d == 9'(LOCK_N)) begin
              state_q <= LOCK;
              good_q  <= '0;
              lock_q  <= 1'b1;
            end else begin
              good_q <= good_d[7:0];
            end
          end
        end
      end else if (cap_tmo && state_q != HUNT) begin
        state_q <= HUNT;
        good_q  <= '0;
        lock_q  <= 1'b0;
        lost_q  <= 1'b1;
      end
    end
  end

  assign sin_out  = sin_q;
  assign m_est    = m_est_q;
  assign period   = period_q;
  assign m_vld    = m_vld_q;
  assign sign_err = sign_err_q;
  assign lock     = lock_q;
  assign lost     = lost_q;

endmodule
